// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator
// Wishbone classic initiator: converts single-word commands into one bus cycle
// each and returns the result through a valid/ready response handshake.
// Only one transaction is outstanding at a time. A bus timeout stops a silent
// responder from hanging the block.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_we/sel/adr/dat is the payload
//   rsp_valid/rsp_ready       response handshake; rsp_dat/rsp_err is the payload
//   wbm_cyc_o .. wbm_dat_o    Wishbone initiator outputs (all registered)
//   wbm_dat_i, wbm_ack_i      Wishbone responder inputs
//   busy                      high whenever the FSM is not in IDLE
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,

  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             cyc_q,       cyc_d;
  logic             we_q,        we_d;
  logic [3:0]       sel_q,       sel_d;
  logic [31:0]      adr_q,       adr_d;
  logic [31:0]      dat_q,       dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q,   rsp_dat_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q,      busy_d;

  // Saturating increment of the wait counter and the timeout condition
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  end

  // State register and all registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        // Ack takes priority over a timeout landing on the same edge
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            cyc_d       = 1'b0;
            rsp_dat_d   = ERR_DATA;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        // rsp_dat/rsp_err deliberately keep their values after the handshake
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Registered flags are derived from the state being entered
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
